// File: rtl/seq_mag_comp_pkg.sv
// Shared types for the sequential magnitude comparator.
// State encoding and one-hot {eq,lt,gt} result constants.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    function automatic logic [2:0] pick_res(input logic lt, input logic gt);
        logic [2:0] r;
        r = RES_EQ;
        if (lt) r = RES_LT;
        else if (gt) r = RES_GT;
        return r;
    endfunction

endpackage

// File: rtl/seq_mag_comp_digit.sv
// Combinational W-bit unsigned compare, usable standalone.
// Ports: a, b (W bits) in; eq, lt, gt one-hot out.
module comp_digit #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle,
// unsigned or two's-complement per transaction.
// Ports: clk, rst_n (async low); in_valid/in_ready, a, b, signed_mode;
// out_valid/out_ready, eq, lt, gt (registered one-hot); busy.
// Option: define SEQ_MAG_COMP_EARLY_EXIT_EN to finish on first
// differing digit instead of always scanning NUM_STEPS digits.
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             busy
);

    localparam int NUM_STEPS = WIDTH / DIGIT;
    localparam int CW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("seq_mag_comp: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    step;
    logic             decided;
    logic [2:0]       res;

    logic             d_eq;
    logic             d_lt;
    logic             d_gt;
    logic [2:0]       fin_res;
    logic             last;
    logic             scan_end;
    logic [WIDTH-1:0] msb_flip;

    comp_digit #(.W(DIGIT)) u_digit (
        .a  (sa[WIDTH-1 -: DIGIT]),
        .b  (sb[WIDTH-1 -: DIGIT]),
        .eq (d_eq),
        .lt (d_lt),
        .gt (d_gt)
    );

    // Flipping the sign bit maps two's complement onto offset binary,
    // so the unsigned digit scan orders signed values correctly.
    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    always_comb begin
        fin_res = decided ? res : pick_res(d_lt, d_gt);
        last    = (step == CW'(NUM_STEPS - 1));
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        scan_end = last || (!decided && !d_eq);
`else
        scan_end = last;
`endif
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state == SCAN) || (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            step      <= '0;
            decided   <= 1'b0;
            res       <= '0;
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa      <= a ^ msb_flip;
                        sb      <= b ^ msb_flip;
                        step    <= '0;
                        decided <= 1'b0;
                        res     <= '0;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                        gt      <= 1'b0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (!decided && !d_eq) begin
                        decided <= 1'b1;
                        res     <= pick_res(d_lt, d_gt);
                    end
                    sa   <= sa << DIGIT;
                    sb   <= sb << DIGIT;
                    step <= step + CW'(1);
                    if (scan_end) begin
                        {eq, lt, gt} <= fin_res;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed table-driven bench for seq_mag_comp (WIDTH=16, DIGIT=2).
// Covers reset, results, latency, backpressure and abort.
module tb_seq_mag_comp;

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic        eq;
    logic        lt;
    logic        gt;
    logic        busy;

    int n_cmp;
    int n_bad;

    seq_mag_comp #(.WIDTH(16), .DIGIT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  res;
        int          lat_def;
        int          lat_early;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat_def;
`endif
    endfunction

    // Present operands; accept happens on the next posedge (T0).
    task automatic start(input logic [15:0] va, input logic [15:0] vb,
                         input logic sm);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_accept", {31'b0, in_ready}, 32'd1);
        a = va;
        b = vb;
        signed_mode = sm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        signed_mode = ~sm;
    endtask

    // Count posedges after T0 until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff(input string name, input logic [2:0] res);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
        check({name, "_idle"}, {31'b0, in_ready}, 32'd1);
        check({name, "_hold"}, {29'b0, eq, lt, gt}, {29'b0, res});
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string nm;
        nm = $sformatf("vec%0d", idx);
        start(v.a, v.b, v.sm);
        check({nm, "_busy"}, {31'b0, busy}, 32'd1);
        wait_done(lat);
        check({nm, "_lat"}, lat, exp_lat(v));
        check({nm, "_res"}, {29'b0, eq, lt, gt}, {29'b0, v.res});
        handoff(nm, v.res);
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{16'hA5A5, 16'hA5A5, 1'b0, R_EQ, 8, 8};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, R_GT, 8, 1};
        vecs[2] = '{16'h0001, 16'h0000, 1'b0, R_GT, 8, 8};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, R_LT, 8, 1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, R_GT, 8, 1};
        vecs[5] = '{16'hFFFF, 16'hFFFE, 1'b1, R_GT, 8, 8};
        vecs[6] = '{16'h0003, 16'h0004, 1'b0, R_LT, 8, 7};
        vecs[7] = '{16'h1234, 16'h1235, 1'b0, R_LT, 8, 8};
        vecs[8] = '{16'h4000, 16'h8000, 1'b0, R_LT, 8, 1};
        vecs[9] = '{16'h0100, 16'h00FF, 1'b0, R_GT, 8, 4};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_res", {29'b0, eq, lt, gt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure: hold DONE, pulse in_valid, nothing may move.
        start(16'h1234, 16'h1235, 1'b0);
        wait_done(lat);
        check("bp_lat", lat, exp_lat(vecs[7]));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0];
            a = 16'hFFFF;
            b = 16'h0000;
            @(posedge clk);
            #1;
            check("bp_ov", {31'b0, out_valid}, 32'd1);
            check("bp_res", {29'b0, eq, lt, gt}, {29'b0, R_LT});
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handoff("bp", R_LT);
        run_vec(vecs[1], 11);

        // Reset while holding a result in DONE clears it immediately.
        start(16'h8000, 16'h7FFF, 1'b0);
        wait_done(lat);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstd_ov", {31'b0, out_valid}, 32'd0);
        check("rstd_res", {29'b0, eq, lt, gt}, 32'd0);
        check("rstd_busy", {31'b0, busy}, 32'd0);
        check("rstd_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort mid-SCAN: that result must never appear.
        start(16'hA5A5, 16'hA5A5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ov", {31'b0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("abort_no_result", lat, 0);
        check("abort_idle", {31'b0, in_ready}, 32'd1);
        run_vec(vecs[6], 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
